// File: rtl/spi_master.sv
// Byte-wide mode-0 SPI master, MSB first, full duplex, with start/busy/done host handshake.
// sclk is produced by an internal divider; every output is a registered flop.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} spiState;

    spiState               state;
    logic [DIV_W-1:0]      divCnt;
    logic [CNT_W-1:0]      bitCnt;
    logic [DATA_WIDTH-1:0] txShift;
    logic [DATA_WIDTH-1:0] rxShift;
    logic                  phaseEnd;

    assign phaseEnd = (divCnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            divCnt  <= '0;
            bitCnt  <= '0;
            txShift <= '0;
            rxShift <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE)
                divCnt <= phaseEnd ? '0 : divCnt + 1'b1;

            case (state)
                IDLE: begin
                    // NOTE: done is still high in the cycle after completion; gating on it
                    // keeps a held start from re-launching until the following cycle.
                    if (start && !done) begin
                        txShift <= tx_data;
                        mosi    <= tx_data[DATA_WIDTH-1];
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        bitCnt  <= '0;
                        divCnt  <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (phaseEnd) begin
                        sclk    <= 1'b1;
                        rxShift <= {rxShift[DATA_WIDTH-2:0], miso};
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (phaseEnd) begin
                        sclk <= 1'b0;
                        if (bitCnt == BIT_LAST) begin
                            state <= HOLD;
                        end else begin
                            bitCnt  <= bitCnt + 1'b1;
                            txShift <= txShift << 1;
                            mosi    <= txShift[DATA_WIDTH-2];
                            state   <= LOW;
                        end
                    end
                end
                HOLD: begin
                    if (phaseEnd) begin
                        cs      <= 1'b1;
                        rx_data <= rxShift;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three builds (CLK_DIV 2, 1, 5), each with a behavioural mode-0 slave.
// Expectations come from frame-level arithmetic: latency (2W+1)*CLK_DIV, bytes swap ends.
module tb_spi_master;

    localparam int W = 8;
    localparam int DIVS [3] = '{2, 1, 5};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start [3];
    logic [W-1:0] txData [3];
    logic [W-1:0] rxData [3];
    logic [W-1:0] slaveDin [3];
    logic         busy [3];
    logic         done [3];
    logic         sclk [3];
    logic         cs [3];
    logic         mosi [3];
    logic         miso [3];

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gSlv
        logic [3:0]   rises = '0;
        logic [W-1:0] dout  = '0;
        int           viol  = 0;
        int           bitPos;
        logic         misoBit;

        spi_master #(.DATA_WIDTH(W), .CLK_DIV(DIVS[g])) dut (
            .clk(clk), .reset(reset), .start(start[g]), .tx_data(txData[g]),
            .rx_data(rxData[g]), .busy(busy[g]), .done(done[g]), .sclk(sclk[g]),
            .cs(cs[g]), .mosi(mosi[g]), .miso(miso[g])
        );

        // Slave captures mosi on sclk rise; selection restarts its bit count.
        always @(negedge cs[g] or posedge sclk[g]) begin
            if (sclk[g]) begin
                dout  <= {dout[W-2:0], mosi[g]};
                rises <= rises + 1'b1;
            end else begin
                dout  <= '0;
                rises <= '0;
            end
        end

        // Bit k is presented from the k-th sclk fall (or selection) until the next fall.
        always_comb begin
            bitPos  = sclk[g] ? int'(rises) - 1 : int'(rises);
            misoBit = 1'b0;
            if (!cs[g] && bitPos >= 0 && bitPos < W)
                misoBit = slaveDin[g][W-1-bitPos];
        end
        assign miso[g] = misoBit;

        always @(negedge clk)
            if (cs[g] === 1'b1 && sclk[g] === 1'b1) viol <= viol + 1;
    end

    function automatic logic [W-1:0] slave_dout(int i);
        case (i)
            0:       return gSlv[0].dout;
            1:       return gSlv[1].dout;
            default: return gSlv[2].dout;
        endcase
    endfunction

    function automatic int slave_rises(int i);
        case (i)
            0:       return int'(gSlv[0].rises);
            1:       return int'(gSlv[1].rises);
            default: return int'(gSlv[2].rises);
        endcase
    endfunction

    function automatic int slave_viol(int i);
        case (i)
            0:       return gSlv[0].viol;
            1:       return gSlv[1].viol;
            default: return gSlv[2].viol;
        endcase
    endfunction

    // Launches one frame; returns edges from acceptance to done, and what both ends received.
    task automatic run_frame(input int i, input logic [W-1:0] tx, input logic [W-1:0] din,
                             output int lat, output logic [W-1:0] rx, output logic [W-1:0] dout,
                             output int rises, output logic doneAfter);
        slaveDin[i] = din;
        txData[i]   = tx;
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i]  = 1'b0;
        txData[i] = W'($urandom);
        lat = 0;
        while (done[i] !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rx    = rxData[i];
        dout  = slave_dout(i);
        rises = slave_rises(i);
        @(posedge clk);
        #1;
        doneAfter = done[i];
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if ({sclk[i], cs[i], mosi[i], busy[i], done[i], rxData[i]} !== {5'b01000, {W{1'b0}}}) begin
                failures++;
                $display("FAIL reset_state dut%0d: sclk=%b cs=%b mosi=%b busy=%b done=%b rx=%h, need 0 1 0 0 0 00",
                         i, sclk[i], cs[i], mosi[i], busy[i], done[i], rxData[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int lat, rises;
        logic [W-1:0] rx, dout;
        logic doneAfter;
        run_frame(0, 8'b11001100, 8'b00110011, lat, rx, dout, rises, doneAfter);
        assertions++;
        if (lat !== (2*W+1)*DIVS[0]) begin
            failures++; $display("FAIL single_latency: got %0d need %0d", lat, (2*W+1)*DIVS[0]);
        end
        assertions++;
        if (rx !== 8'b00110011) begin
            failures++; $display("FAIL single_rx: got %b need 00110011", rx);
        end
        assertions++;
        if (dout !== 8'b11001100) begin
            failures++; $display("FAIL single_slave_dout: got %b need 11001100", dout);
        end
        assertions++;
        if (rises !== W) begin
            failures++; $display("FAIL single_sclk_rises: got %0d need %0d", rises, W);
        end
        assertions++;
        if (doneAfter !== 1'b0) begin
            failures++; $display("FAIL single_done_width: done still %b one cycle later, need 0", doneAfter);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] txs [4] = '{8'b11000011, 8'b11110000, 8'b10010011, 8'b10110010};
        logic [W-1:0] dins [4] = '{8'b10101010, 8'b01110001, 8'b10010000, 8'b10100101};
        int lat, rises;
        logic [W-1:0] rx, dout;
        logic doneAfter;
        for (int k = 0; k < 4; k++) begin
            run_frame(0, txs[k], dins[k], lat, rx, dout, rises, doneAfter);
            assertions++;
            if (rx !== dins[k] || dout !== txs[k] || lat !== (2*W+1)*DIVS[0]) begin
                failures++;
                $display("FAIL b2b_frame%0d: rx=%b dout=%b lat=%0d, need rx=%b dout=%b lat=%0d",
                         k, rx, dout, lat, dins[k], txs[k], (2*W+1)*DIVS[0]);
            end
            assertions++;
            if (cs[0] !== 1'b1) begin
                failures++; $display("FAIL b2b_cs_gap%0d: cs=%b between frames, need 1", k, cs[0]);
            end
        end
    endtask

    task automatic test_random(input int i, input int n);
        int lat, rises;
        logic [W-1:0] rx, dout, tx, din;
        logic doneAfter;
        for (int k = 0; k < n; k++) begin
            tx  = W'($urandom);
            din = W'($urandom);
            run_frame(i, tx, din, lat, rx, dout, rises, doneAfter);
            assertions++;
            if (rx !== din || dout !== tx || lat !== (2*W+1)*DIVS[i] || rises !== W) begin
                failures++;
                $display("FAIL random_dut%0d_frame%0d: rx=%h dout=%h lat=%0d rises=%0d, need rx=%h dout=%h lat=%0d rises=%0d",
                         i, k, rx, dout, lat, rises, din, tx, (2*W+1)*DIVS[i], W);
            end
        end
    endtask

    // Held start: frames occupy 36-cycle slots (34 busy, done cycle, one idle cycle).
    task automatic test_start_held();
        logic [W-1:0] tx, din;
        int slot, pos;
        logic expBusy, expDone;
        tx  = W'($urandom);
        din = W'($urandom);
        txData[0]   = tx;
        slaveDin[0] = din;
        slot = (2*W+1)*DIVS[0] + 2;
        @(negedge clk);
        start[0] = 1'b1;
        for (int t = 0; t < 2*slot; t++) begin
            @(posedge clk);
            #1;
            pos     = t % slot;
            expBusy = (pos < slot - 2);
            expDone = (pos == slot - 2);
            assertions++;
            if (busy[0] !== expBusy || done[0] !== expDone) begin
                failures++;
                $display("FAIL held_start_t%0d: busy=%b done=%b, need busy=%b done=%b",
                         t, busy[0], done[0], expBusy, expDone);
            end
            if (expDone) begin
                assertions++;
                if (rxData[0] !== din || slave_dout(0) !== tx) begin
                    failures++;
                    $display("FAIL held_start_data_t%0d: rx=%h dout=%h, need rx=%h dout=%h",
                             t, rxData[0], slave_dout(0), din, tx);
                end
            end
        end
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int waitCnt, lat, rises;
        logic sawDone;
        logic [W-1:0] rx, dout, din;
        slaveDin[0] = W'($urandom) | 8'h01;
        txData[0]   = W'($urandom);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        waitCnt = 0;
        while (slave_rises(0) < 4 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        assertions++;
        if (waitCnt >= 200) begin
            failures++; $display("FAIL reset_mid_reach_bit4: rises=%0d after timeout, need 4", slave_rises(0));
        end
        #2;
        reset = 1'b1;
        #1;
        assertions++;
        if ({sclk[0], cs[0], busy[0], done[0], rxData[0]} !== {4'b0100, {W{1'b0}}}) begin
            failures++;
            $display("FAIL reset_mid_immediate: sclk=%b cs=%b busy=%b done=%b rx=%h, need 0 1 0 0 00",
                     sclk[0], cs[0], busy[0], done[0], rxData[0]);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done[0] === 1'b1) sawDone = 1'b1;
        end
        assertions++;
        if (sawDone !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_done: done seen after aborted frame, need none");
        end
        din = W'($urandom);
        run_frame(0, 8'hA5, din, lat, rx, dout, rises, sawDone);
        assertions++;
        if (rx !== din || dout !== 8'hA5 || lat !== (2*W+1)*DIVS[0]) begin
            failures++;
            $display("FAIL reset_mid_recover: rx=%h dout=%h lat=%0d, need rx=%h dout=a5 lat=%0d",
                     rx, dout, lat, din, (2*W+1)*DIVS[0]);
        end
    endtask

    task automatic test_clk_div();
        int lat, rises;
        logic [W-1:0] rx, dout;
        logic doneAfter;
        for (int i = 1; i < 3; i++) begin
            run_frame(i, 8'h5A, 8'hC3, lat, rx, dout, rises, doneAfter);
            assertions++;
            if (lat !== (2*W+1)*DIVS[i]) begin
                failures++; $display("FAIL clkdiv%0d_latency: got %0d need %0d", DIVS[i], lat, (2*W+1)*DIVS[i]);
            end
            assertions++;
            if (rx !== 8'hC3 || dout !== 8'h5A || rises !== W) begin
                failures++;
                $display("FAIL clkdiv%0d_data: rx=%h dout=%h rises=%0d, need rx=c3 dout=5a rises=%0d",
                         DIVS[i], rx, dout, rises, W);
            end
            test_random(i, 3);
        end
    endtask

    task automatic test_sclk_idle();
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if (slave_viol(i) !== 0) begin
                failures++; $display("FAIL sclk_high_while_deselected dut%0d: %0d cycles, need 0", i, slave_viol(i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i]    = 1'b0;
            txData[i]   = '0;
            slaveDin[i] = '0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_random(0, 6);
        test_start_held();
        test_reset_mid();
        test_clk_div();
        test_sclk_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI master that drives the existing SPI slave directly: generates sclk, cs, MOSI and samples MISO.
- Runs from one system clock. sclk is derived by an internal divider.
- Mode 0 framing, MSB first, full duplex. One byte is shifted each way per transaction.
- Host side uses a start/busy/done handshake. The last received byte is held on rx_data.

Parameters:
- DATA_WIDTH, 8: bits per transaction.
- CLK_DIV, 2: sclk half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- tx_data  input  DATA_WIDTH  byte to send; latched on the accepted start.
- rx_data  output  DATA_WIDTH  byte received in the last completed transaction.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse when a transaction completes.
- sclk  output  1  serial clock to the slave; idles low.
- cs  output  1  chip select, active low; idles high.
- mosi  output  1  serial data to the slave.
- miso  input  1  serial data from the slave.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE; sclk=0, cs=1, mosi=0, busy=0, done=0, rx_data=0.
  - Shift registers, bit counter and divider are cleared.
- Divider: div_cnt counts 0..CLK_DIV-1 within each phase. A phase ends on the edge where div_cnt==CLK_DIV-1, and div_cnt then returns to 0.
- States and transitions:
  - IDLE: on start=1, latch tx_data into tx_shift. Set cs=0, mosi=tx_data[MSB], busy=1, bit_cnt=0, then go to SETUP. With start=0, stay in IDLE.
  - SETUP: at phase end, set sclk=1 and shift miso into rx_shift LSB, then go to HIGH.
  - HIGH: at phase end, set sclk=0.
    - If bit_cnt==DATA_WIDTH-1, go to HOLD.
    - Otherwise bit_cnt++, shift tx_shift left, drive mosi with the new MSB, and go to LOW.
  - LOW: at phase end, set sclk=1 and shift miso into rx_shift LSB, then go to HIGH.
  - HOLD: at phase end, set cs=1, rx_data=rx_shift, done=1 for exactly one clk cycle and busy=0, then go to IDLE.
- sclk protocol:
  - mosi changes only while sclk is low (on the falling edge, or at cs assertion for the first bit).
  - miso is sampled on the clk edge that raises sclk.
  - A transaction has exactly DATA_WIDTH rising sclk edges.
  - sclk is 0 whenever cs=1.
- Latency: done is high after clk edge start_edge + (2*DATA_WIDTH+1)*CLK_DIV. With defaults this is 34 cycles.
- start is ignored while busy=1, including during the done cycle. start in the cycle after done begins a new transaction.
- tx_data changes after acceptance have no effect on the frame in flight.
- rx_data holds its value until the next done; it is never partially updated.
- Reset during a frame: cs returns high immediately (asynchronously). No done is produced. rx_data=0.

Test Plan:
- Single transfer: tx_data=8'b11001100, slave din=8'b00110011, CLK_DIV=2 -> the following must hold:
  - done pulses exactly 34 clk after start.
  - rx_data=8'b00110011.
  - slave dout=8'b11001100.
  - Exactly 8 sclk rising edges occur while cs=0.
- Back-to-back: the pairs below each return the slave byte on rx_data, and the master byte on slave dout, with cs high ≥1 cycle between frames:
  - 11000011/10101010
  - 11110000/01110001
  - 10010011/10010000
  - 10110010/10100101
- start held high through a whole frame -> the following must hold:
  - The second frame begins only the cycle after done.
  - busy never drops mid-frame.
  - There is one done per frame.
- Reset asserted at bit 4 of a frame -> the following must hold:
  - sclk=0, cs=1, busy=0, rx_data=0 immediately.
  - No done is produced.
  - A following start with 8'hA5 completes correctly.
- CLK_DIV=1 and CLK_DIV=5 builds -> done at 17 and 85 cycles respectively, with correct data both ways for 8'h5A/8'hC3.
